asmd_mult_arbiter: RTL
======================

ASMD_MULT_ARBITER -- requirements
Module: asmd_mult_arbiter

Interface
REQ-001 Parameter: word_length, default 4, operand width of each requester and of the shared asmd multiplier.
REQ-002 Parameter: num_req, fixed 4, number of requesters (fixed at 4 in this release).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester level request; bit i is held high until done[i].
REQ-006 req_word0  input  4*word_length  packed operand A; slice i belongs to requester i.
REQ-007 req_word1  input  4*word_length  packed operand B; slice i belongs to requester i.
REQ-008 grant  output  4  one-hot; bit i is high for the single issue cycle of requester i.
REQ-009 done  output  4  one-hot, 1-cycle pulse; bit i marks result valid for requester i.
REQ-010 result  output  2*word_length  last captured product; stable until the next done pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mult_start  output  1  start pulse to the shared multiplier.
REQ-013 mult_word0 / mult_word1  output  word_length each  operands driven to the multiplier.
REQ-014 mult_ready  input  1  multiplier idle/complete flag.
REQ-015 mult_product  input  2*word_length  multiplier product.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
REQ-017 IDLE: if req!=0 and mult_ready=1, select winner, latch its operands, go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration: round-robin; search starts at rr_ptr and wraps at index 3; rr_ptr resets to 0.
REQ-019 ISSUE (1 cycle): grant[winner]=1, mult_start=1, mult_word0/1 = latched operands; then go to WAIT_LOW.
REQ-020 Latched operands: held on mult_word0/1 from ISSUE through DONE; requester inputs may change after grant.
REQ-021 WAIT_LOW: stay until mult_ready=0, then go to WAIT_HIGH.
REQ-022 WAIT_HIGH: stay until mult_ready=1; on that edge capture mult_product into result and go to DONE.
REQ-023 DONE (1 cycle): done[winner]=1; rr_ptr = (winner+1) mod 4; go to IDLE.
REQ-024 Latency: from req sampled in IDLE to grant is 1 cycle; done asserts exactly 1 cycle after mult_ready returns high.
REQ-025 Throughput: minimum 1 IDLE cycle between consecutive operations.
REQ-026 Requester drops req after grant: the operation still completes and done[i] still pulses.
REQ-027 Simultaneous requests: exactly one grant per operation; no requester waits more than 3 other operations.
REQ-028 Operand widths: no truncation; result is the full 2*word_length mult_product (15*15=225 for word_length=4).
REQ-029 mult_start, grant and done are never high outside ISSUE/DONE; grant and done are each at most one-hot.

Reset
REQ-030 When reset=1 at a clock edge: state=IDLE, rr_ptr=0, grant=0, done=0, mult_start=0, busy=0, result=0, mult_word0/1=0, regardless of the current state.
REQ-031 Reset mid-operation abandons the operation with no done pulse; the multiplier shares the same reset.

Verification
REQ-032 Single requester: req=0001, word0=4, word1=5 -> grant=0001 for 1 cycle; done=0001; result=20.
REQ-033 All requesters asserted, operands (1,2),(3,4),(5,6),(15,15) -> done order 0,1,2,3; results 2,12,30,225.
REQ-034 Fairness: req0 held continuously with req2 also high -> grants alternate 0,2,0,2.
REQ-035 Reset asserted during WAIT_HIGH -> no done pulse; all outputs at their reset values the next cycle; the next req is served normally.
REQ-036 req1 dropped after grant, operands 7*9 -> done=0010 still pulses; result=63.
REQ-037 mult_ready held low in IDLE with req=0100 -> no grant until mult_ready=1.

Source files
------------

// File: rtl/asmd_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : asmd_mult_arbiter
//  Purpose  : Round-robin arbiter that shares one handshake-driven (ASMD)
//             multiplier among four requesters. The winner's operands are
//             latched, one start pulse is issued, and the arbiter waits for
//             the multiplier's ready flag to fall and rise again. The product
//             is then captured and the winner receives a one-cycle done pulse.
//  Ports    :
//    clk          in   system clock, rising edge
//    reset        in   synchronous, active-high reset
//    req          in   [num_req]       level request per requester
//    req_word0    in   [num_req*W]     packed operand A, slice i = requester i
//    req_word1    in   [num_req*W]     packed operand B, slice i = requester i
//    grant        out  [num_req]       one-hot, high during the issue cycle
//    done         out  [num_req]       one-hot, one-cycle result-valid pulse
//    result       out  [2*W]           last captured product
//    busy         out                  high whenever not idle
//    mult_start   out                  start pulse to the multiplier
//    mult_word0/1 out  [W]             latched operands to the multiplier
//    mult_ready   in                   multiplier idle/complete flag
//    mult_product in   [2*W]           multiplier product
//  Revision : 1.0  initial release
// ============================================================================
module asmd_mult_arbiter #(
  parameter int word_length = 4,
  parameter int num_req     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*word_length-1:0] req_word0,
  input  logic [num_req*word_length-1:0] req_word1,
  output logic [num_req-1:0]             grant,
  output logic [num_req-1:0]             done,
  output logic [2*word_length-1:0]       result,
  output logic                           busy,
  output logic                           mult_start,
  output logic [word_length-1:0]         mult_word0,
  output logic [word_length-1:0]         mult_word1,
  input  logic                           mult_ready,
  input  logic [2*word_length-1:0]       mult_product
);

  localparam int c_PTR_W = $clog2(num_req);
  localparam logic [num_req-1:0] c_ONE = {{(num_req-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] r_winner;
  logic [c_PTR_W-1:0] w_winner;
  logic [c_PTR_W-1:0] w_idx;

  // Round-robin pick: scan from r_ptr upwards with wrap-around. The loop runs
  // from the farthest offset down to offset 0 so the nearest requester to the
  // pointer is the last assignment and therefore wins.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      w_idx = r_ptr + k[c_PTR_W-1:0];
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_winner   <= '0;
      grant      <= '0;
      done       <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      mult_word0 <= '0;
      mult_word1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only start when the shared multiplier reports idle, otherwise the
          // start pulse could be lost.
          if ((|req) && mult_ready) begin
            r_winner   <= w_winner;
            mult_word0 <= req_word0[int'(w_winner)*word_length +: word_length];
            mult_word1 <= req_word1[int'(w_winner)*word_length +: word_length];
            grant      <= c_ONE << w_winner;
            mult_start <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          grant      <= '0;
          mult_start <= 1'b0;
          r_state    <= S_WAIT_LOW;
        end

        // Wait for the multiplier to acknowledge the start by dropping ready,
        // so a stale ready level is never mistaken for completion.
        S_WAIT_LOW: begin
          if (!mult_ready) begin
            r_state <= S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          if (mult_ready) begin
            result  <= mult_product;
            done    <= c_ONE << r_winner;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= '0;
          r_ptr   <= r_winner + 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          grant      <= '0;
          done       <= '0;
          mult_start <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
